// File: rtl/pipe_run_ctrl_if.sv
// Control bundle between the run sequencer and the pipeline / host side.
// master: drives run requests and ID-stage hazard status, observes controls and statistics.
// slave : the sequencer itself.
interface pipe_run_ctrl_if;
  // requests and operands
  logic        start;
  logic        abort;
  logic [31:0] op_floors;
  logic [31:0] op_resistance;
  // ID-stage hazard status
  logic        stall;
  logic        branch;
  logic        halt;
  // register-file initialisation
  logic [31:0] init_floors;
  logic [31:0] init_resistance;
  logic        rf_init;
  logic        pc_clear;
  // pipeline controls
  logic        pipe_en;
  logic        pc_hold;
  logic        if_id_hold;
  logic        if_id_flush;
  logic        id_ex_bubble;
  // status and statistics
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  modport master (
    output start, abort, op_floors, op_resistance, stall, branch, halt,
    input  init_floors, init_resistance, rf_init, pc_clear, pipe_en, pc_hold,
           if_id_hold, if_id_flush, id_ex_bubble, busy, done, timeout,
           cycle_count, stall_count, flush_count
  );

  modport slave (
    input  start, abort, op_floors, op_resistance, stall, branch, halt,
    output init_floors, init_resistance, rf_init, pc_clear, pipe_en, pc_hold,
           if_id_hold, if_id_flush, id_ex_bubble, busy, done, timeout,
           cycle_count, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run sequencer for the 5-stage pipeline: IDLE -> INIT -> RUN -> DRAIN -> DONE.
// Latches operands, initialises the register file, converts ID-stage stall/branch/halt
// into PC/IF/ID/ID-EX controls, drains after halt and keeps run statistics.
// Optional macro PIPE_STAT_EN: when defined, stall/flush statistics counters are built;
// otherwise those outputs are tied to zero.
module pipe_run_ctrl #(
  parameter int unsigned INIT_CYCLES  = 2,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] MAX_CYCLES   = 32'd100000
) (
  input logic          clk_i,
  input logic          rst_i,
  pipe_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] floors_reg, resistance_reg, cycle_reg;
  logic        busy_reg, done_reg, timeout_reg;
  logic        accept, timeout_hit, count_en, run_en;
  logic [31:0] cycle_inc;
  logic        rf_init, pc_clear, pipe_en, pc_hold, if_id_hold, if_id_flush, id_ex_bubble;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign cycle_inc = sat_inc(cycle_reg);
  // Counters only advance in RUN/DRAIN, and an abort freezes them in the cycle it is seen.
  assign count_en  = (state_reg == S_RUN || state_reg == S_DRAIN) && !bus.abort;
  assign run_en    = (state_reg == S_RUN) && !bus.abort;

  // Next-state, down-counter and combinational pipeline controls.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    accept       = 1'b0;
    timeout_hit  = 1'b0;
    rf_init      = 1'b0;
    pc_clear     = 1'b0;
    pipe_en      = 1'b0;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          cnt_next   = 32'(INIT_CYCLES - 1);
          state_next = S_INIT;
        end
      end
      S_INIT: begin
        rf_init  = 1'b1;
        pc_clear = 1'b1;
        if (cnt_reg == 32'd0) state_next = S_RUN;
        else                  cnt_next   = cnt_reg - 32'd1;
      end
      S_RUN: begin
        pipe_en = 1'b1;
        // A stalled ID stage holds stale operands, so branch/halt are not trusted then.
        if (bus.stall) begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (bus.halt) begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
          cnt_next    = 32'(DRAIN_CYCLES - 1);
          state_next  = S_DRAIN;
        end else if (bus.branch) begin
          if_id_flush = 1'b1;
        end
        // Watchdog wins over a halt seen in the same cycle.
        if (cycle_inc >= MAX_CYCLES) begin
          timeout_hit = 1'b1;
          state_next  = S_DONE;
        end
      end
      S_DRAIN: begin
        pipe_en     = 1'b1;
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        if (cnt_reg == 32'd0) state_next = S_DONE;
        else                  cnt_next   = cnt_reg - 32'd1;
      end
      default: state_next = S_IDLE;
    endcase
    if (bus.abort) begin
      state_next  = S_IDLE;
      cnt_next    = 32'd0;
      accept      = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  // State, operand latches, registered status flags and the cycle counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 32'd0;
      floors_reg     <= 32'd0;
      resistance_reg <= 32'd0;
      cycle_reg      <= 32'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next == S_INIT) || (state_next == S_RUN) || (state_next == S_DRAIN);
      done_reg  <= (state_next == S_DONE);
      if (accept) begin
        floors_reg     <= bus.op_floors;
        resistance_reg <= bus.op_resistance;
        cycle_reg      <= 32'd0;
        timeout_reg    <= 1'b0;
      end else begin
        if (count_en)    cycle_reg   <= cycle_inc;
        if (timeout_hit) timeout_reg <= 1'b1;
      end
    end
  end

`ifdef PIPE_STAT_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg;

  // Stall/flush statistics over RUN cycles only.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else if (accept) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else if (run_en) begin
      if (bus.stall)  stall_cnt_reg <= sat_inc(stall_cnt_reg);
      if (if_id_flush) flush_cnt_reg <= sat_inc(flush_cnt_reg);
    end
  end

  assign bus.stall_count = stall_cnt_reg;
  assign bus.flush_count = flush_cnt_reg;
`else
  logic unused_run_en;
  assign unused_run_en   = run_en;
  assign bus.stall_count = 32'd0;
  assign bus.flush_count = 32'd0;
`endif

  assign bus.init_floors     = floors_reg;
  assign bus.init_resistance = resistance_reg;
  assign bus.rf_init         = rf_init;
  assign bus.pc_clear        = pc_clear;
  assign bus.pipe_en         = pipe_en;
  assign bus.pc_hold         = pc_hold;
  assign bus.if_id_hold      = if_id_hold;
  assign bus.if_id_flush     = if_id_flush;
  assign bus.id_ex_bubble    = id_ex_bubble;
  assign bus.busy            = busy_reg;
  assign bus.done            = done_reg;
  assign bus.timeout         = timeout_reg;
  assign bus.cycle_count     = cycle_reg;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl (watchdog limit shortened to 20 cycles).
// Inputs change 1 time unit after a rising edge; outputs are checked one more unit later.
module tb_pipe_run_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  pipe_run_ctrl_if bus();

  pipe_run_ctrl #(
    .INIT_CYCLES (2),
    .DRAIN_CYCLES(3),
    .MAX_CYCLES  (32'd20)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

`ifdef PIPE_STAT_EN
  localparam logic [31:0] EXP_ONE = 32'd1;
  localparam logic [31:0] EXP_TWO = 32'd2;
`else
  localparam logic [31:0] EXP_ONE = 32'd0;
  localparam logic [31:0] EXP_TWO = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns in the first INIT cycle.
  task automatic start_run(input logic [31:0] floors, input logic [31:0] res);
    bus.start         = 1'b1;
    bus.op_floors     = floors;
    bus.op_resistance = res;
    tick();
    bus.start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b1;
    bus.op_floors = 32'd5;
    tick();
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    n_cmp++; if (bus.rf_init !== 1'b0) begin n_fail++; $display("FAIL reset_rf_init: got %0b want 0", bus.rf_init); end
    n_cmp++; if (bus.pipe_en !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_en: got %0b want 0", bus.pipe_en); end
    n_cmp++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b want 0", bus.timeout); end
    n_cmp++; if (bus.init_floors !== 32'd0) begin n_fail++; $display("FAIL reset_floors: got %0d want 0", bus.init_floors); end
    n_cmp++; if (bus.cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", bus.cycle_count); end
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_start: busy got %0b want 0", bus.busy); end
    $display("test_reset done");
  endtask

  task automatic test_run();
    start_run(32'd100, 32'd14);
    n_cmp++; if (bus.rf_init !== 1'b1) begin n_fail++; $display("FAIL run_rf_init1: got %0b want 1", bus.rf_init); end
    n_cmp++; if (bus.pc_clear !== 1'b1) begin n_fail++; $display("FAIL run_pc_clear: got %0b want 1", bus.pc_clear); end
    n_cmp++; if (bus.init_floors !== 32'd100) begin n_fail++; $display("FAIL run_floors: got %0d want 100", bus.init_floors); end
    n_cmp++; if (bus.init_resistance !== 32'd14) begin n_fail++; $display("FAIL run_res: got %0d want 14", bus.init_resistance); end
    n_cmp++; if (bus.pipe_en !== 1'b0) begin n_fail++; $display("FAIL run_init_pipe_en: got %0b want 0", bus.pipe_en); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL run_busy: got %0b want 1", bus.busy); end
    tick();
    n_cmp++; if (bus.rf_init !== 1'b1) begin n_fail++; $display("FAIL run_rf_init2: got %0b want 1", bus.rf_init); end
    tick();
    n_cmp++; if (bus.rf_init !== 1'b0) begin n_fail++; $display("FAIL run_rf_init3: got %0b want 0", bus.rf_init); end
    n_cmp++; if (bus.pipe_en !== 1'b1) begin n_fail++; $display("FAIL run_pipe_en: got %0b want 1", bus.pipe_en); end
    n_cmp++; if (bus.pc_hold !== 1'b0) begin n_fail++; $display("FAIL run_idle_hold: got %0b want 0", bus.pc_hold); end
    repeat (9) tick();
    bus.halt = 1'b1;
    #1;
    n_cmp++; if (bus.pc_hold !== 1'b1) begin n_fail++; $display("FAIL run_halt_hold: got %0b want 1", bus.pc_hold); end
    n_cmp++; if (bus.if_id_flush !== 1'b1) begin n_fail++; $display("FAIL run_halt_flush: got %0b want 1", bus.if_id_flush); end
    tick();
    bus.halt = 1'b0;
    #1;
    n_cmp++; if (bus.cycle_count !== 32'd10) begin n_fail++; $display("FAIL drain_cycles: got %0d want 10", bus.cycle_count); end
    n_cmp++; if ({bus.pipe_en, bus.pc_hold, bus.if_id_flush} !== 3'b111) begin n_fail++; $display("FAIL drain_ctrl: got %0b want 111", {bus.pipe_en, bus.pc_hold, bus.if_id_flush}); end
    repeat (3) tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL run_done: got %0b want 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL run_done_busy: got %0b want 0", bus.busy); end
    n_cmp++; if (bus.cycle_count !== 32'd13) begin n_fail++; $display("FAIL run_cycles: got %0d want 13", bus.cycle_count); end
    n_cmp++; if (bus.pipe_en !== 1'b0) begin n_fail++; $display("FAIL run_done_pipe_en: got %0b want 0", bus.pipe_en); end
    tick();
    n_cmp++; if (bus.cycle_count !== 32'd13) begin n_fail++; $display("FAIL run_frozen: got %0d want 13", bus.cycle_count); end
    $display("test_run done");
  endtask

  task automatic test_hazards();
    start_run(32'd7, 32'd3);
    tick();
    tick();
    bus.stall = 1'b1;
    bus.branch = 1'b1;
    #1;
    n_cmp++; if ({bus.pc_hold, bus.if_id_hold, bus.id_ex_bubble} !== 3'b111) begin n_fail++; $display("FAIL haz_stall_ctrl: got %0b want 111", {bus.pc_hold, bus.if_id_hold, bus.id_ex_bubble}); end
    n_cmp++; if (bus.if_id_flush !== 1'b0) begin n_fail++; $display("FAIL haz_stall_flush: got %0b want 0", bus.if_id_flush); end
    tick();
    bus.stall = 1'b0;
    #1;
    n_cmp++; if (bus.if_id_flush !== 1'b1) begin n_fail++; $display("FAIL haz_branch_flush: got %0b want 1", bus.if_id_flush); end
    n_cmp++; if ({bus.pc_hold, bus.if_id_hold, bus.id_ex_bubble} !== 3'b000) begin n_fail++; $display("FAIL haz_branch_hold: got %0b want 000", {bus.pc_hold, bus.if_id_hold, bus.id_ex_bubble}); end
    tick();
    bus.branch = 1'b0;
    #1;
    n_cmp++; if (bus.stall_count !== EXP_ONE) begin n_fail++; $display("FAIL haz_stall_count: got %0d want %0d", bus.stall_count, EXP_ONE); end
    n_cmp++; if (bus.flush_count !== EXP_ONE) begin n_fail++; $display("FAIL haz_flush_count: got %0d want %0d", bus.flush_count, EXP_ONE); end
    bus.halt = 1'b1;
    tick();
    bus.stall = 1'b1;
    #1;
    n_cmp++; if ({bus.if_id_hold, bus.id_ex_bubble} !== 2'b00) begin n_fail++; $display("FAIL haz_drain_ignore: got %0b want 00", {bus.if_id_hold, bus.id_ex_bubble}); end
    bus.stall = 1'b0;
    bus.halt = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.cycle_count !== 32'd6) begin n_fail++; $display("FAIL haz_cycles: got %0d want 6", bus.cycle_count); end
    n_cmp++; if (bus.flush_count !== EXP_TWO) begin n_fail++; $display("FAIL haz_flush_final: got %0d want %0d", bus.flush_count, EXP_TWO); end
    n_cmp++; if (bus.stall_count !== EXP_ONE) begin n_fail++; $display("FAIL haz_stall_final: got %0d want %0d", bus.stall_count, EXP_ONE); end
    $display("test_hazards done");
  endtask

  task automatic test_watchdog();
    start_run(32'd9, 32'd9);
    tick();
    tick();
    repeat (19) tick();
    n_cmp++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early_timeout: got %0b want 0", bus.timeout); end
    n_cmp++; if (bus.cycle_count !== 32'd19) begin n_fail++; $display("FAIL wd_cycles19: got %0d want 19", bus.cycle_count); end
    tick();
    n_cmp++; if (bus.timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout: got %0b want 1", bus.timeout); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wd_done: got %0b want 1", bus.done); end
    n_cmp++; if (bus.cycle_count !== 32'd20) begin n_fail++; $display("FAIL wd_cycles: got %0d want 20", bus.cycle_count); end
    $display("test_watchdog done");
  endtask

  task automatic test_abort();
    start_run(32'd55, 32'd66);
    n_cmp++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL abort_timeout_clr: got %0b want 0", bus.timeout); end
    tick();
    tick();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0b want 0", bus.done); end
    n_cmp++; if (bus.pc_hold !== 1'b0) begin n_fail++; $display("FAIL abort_hold: got %0b want 0", bus.pc_hold); end
    n_cmp++; if (bus.cycle_count !== 32'd1) begin n_fail++; $display("FAIL abort_cycles: got %0d want 1", bus.cycle_count); end
    n_cmp++; if (bus.init_floors !== 32'd55) begin n_fail++; $display("FAIL abort_floors: got %0d want 55", bus.init_floors); end
    $display("test_abort done");
  endtask

  task automatic test_restart();
    start_run(32'd1, 32'd2);
    tick();
    tick();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done: got %0b want 1", bus.done); end
    start_run(32'd36, 32'd4);
    n_cmp++; if (bus.init_floors !== 32'd36) begin n_fail++; $display("FAIL restart_floors: got %0d want 36", bus.init_floors); end
    n_cmp++; if (bus.cycle_count !== 32'd0) begin n_fail++; $display("FAIL restart_cycles: got %0d want 0", bus.cycle_count); end
    n_cmp++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL restart_timeout: got %0b want 0", bus.timeout); end
    n_cmp++; if ({bus.rf_init, bus.busy, bus.done} !== 3'b110) begin n_fail++; $display("FAIL restart_init: got %0b want 110", {bus.rf_init, bus.busy, bus.done}); end
    $display("test_restart done");
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op_floors = 32'd0;
    bus.op_resistance = 32'd0;
    bus.stall = 1'b0;
    bus.branch = 1'b0;
    bus.halt = 1'b0;
    test_reset();
    test_run();
    test_hazards();
    test_watchdog();
    test_abort();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
